barrel_shift_pipe: RTL and testbench

Parametrised, pipelined barrel shifter/rotator for the ALU datapath, the successor to the 32-bit combinational rotator. It supports WIDTH-bit operands and five operations: rotate left/right, logical shift left/right, and arithmetic shift right. It has a configurable register latency, valid/ready flow control with back-pressure, and result flags (zero, carry-out, illegal op). It sits between the operand-select stage and the ALU result mux, and carries an opaque tag so results can be matched to issuing instructions.

---
 rtl/barrel_shift_if.sv | 33 +++
 rtl/barrel_shift_pipe.sv | 115 +++++++++++
 tb/tb_barrel_shift_pipe.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/barrel_shift_if.sv
// Request/result bus of the pipelined barrel shifter.
// The master side issues operands and consumes results; the slave side is the shifter.
interface barrel_shift_if #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4
);
    localparam int SW = $clog2(WIDTH);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [SW-1:0]    in_amt;
    logic [2:0]       in_op;
    logic [TAG_W-1:0] in_tag;

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_carry;
    logic             out_zero;
    logic             out_err;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output in_valid, in_data, in_amt, in_op, in_tag, out_ready,
        input  in_ready, out_valid, out_data, out_carry, out_zero, out_err, out_tag
    );

    modport slave (
        input  in_valid, in_data, in_amt, in_op, in_tag, out_ready,
        output in_ready, out_valid, out_data, out_carry, out_zero, out_err, out_tag
    );
endinterface

// File: rtl/barrel_shift_pipe.sv
// Pipelined barrel shifter/rotator: ROL, ROR, SLL, SRL, SRA over WIDTH-bit operands.
// The SW shift levels are split evenly across LAT register stages; a single global
// advance moves the whole pipeline, carrying bubbles rather than collapsing them.
module barrel_shift_pipe #(
    parameter int WIDTH = 32,
    parameter int LAT   = 2,
    parameter int TAG_W = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    barrel_shift_if.slave bus
);
    localparam int SW  = $clog2(WIDTH);
    // Shift levels handled in front of each stage register (ceiling division).
    localparam int LPS = (SW + LAT - 1) / LAT;

    localparam logic [2:0] OP_ROL = 3'b000;
    localparam logic [2:0] OP_ROR = 3'b001;
    localparam logic [2:0] OP_SLL = 3'b010;
    localparam logic [2:0] OP_SRL = 3'b011;
    localparam logic [2:0] OP_SRA = 3'b100;

    // Contents of one pipeline stage; amt is the full amount, each stage consumes its own bits.
    typedef struct packed {
        logic             valid;
        logic [WIDTH-1:0] data;
        logic [SW-1:0]    amt;
        logic [2:0]       op;
        logic             carry;
        logic [TAG_W-1:0] tag;
    } stage_t;

    // Apply shift levels lo..hi-1. For shifts the carry tracks the last bit pushed out:
    // whichever level is applied last, that bit is d[WIDTH-n] (left) or d[n-1] (right).
    // Rotate carries come from the final data at the output; illegal ops pass through.
    function automatic stage_t shift_levels(input stage_t st, input int lo, input int hi);
        stage_t r;
        int     sh;
        r = st;
        for (int k = 0; k < SW; k++) begin
            if (k >= lo && k < hi && r.amt[k] && r.op <= OP_SRA) begin
                sh = 1 << k;
                case (r.op)
                    OP_ROL: r.data = (r.data << sh) | (r.data >> (WIDTH - sh));
                    OP_ROR: r.data = (r.data >> sh) | (r.data << (WIDTH - sh));
                    OP_SLL: begin
                        r.carry = r.data[WIDTH-sh];
                        r.data  = r.data << sh;
                    end
                    OP_SRL: begin
                        r.carry = r.data[sh-1];
                        r.data  = r.data >> sh;
                    end
                    default: begin
                        r.carry = r.data[sh-1];
                        r.data  = $signed(r.data) >>> sh;
                    end
                endcase
            end
        end
        return r;
    endfunction

    // Carry flag of a completed result.
    function automatic logic final_carry(input stage_t st);
        case (st.op)
            OP_ROL:                 return st.data[0];
            OP_ROR:                 return st.data[WIDTH-1];
            OP_SLL, OP_SRL, OP_SRA: return st.carry;
            default:                return 1'b0;
        endcase
    endfunction

    logic   advance;
    stage_t in_stage;

    assign in_stage = '{valid: bus.in_valid, data: bus.in_data, amt: bus.in_amt,
                        op: bus.in_op, carry: 1'b0, tag: bus.in_tag};

    for (genvar s = 0; s < LAT; s++) begin : g_stage
        stage_t src;
        stage_t q;

        if (s == 0) begin : g_head
            assign src = in_stage;
        end else begin : g_body
            assign src = g_stage[s-1].q;
        end

        // Stage s: on advance load the shifted predecessor; a bubble only clears valid so
        // the output payload keeps showing the last result instead of stale junk.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                // NOTE: payload is reset too (not just valid) because the output pins
                // expose the last stage directly and must read 0 / zero=1 after reset.
                q <= '0;
            end else if (advance) begin
                // NOTE: non-blocking so every stage samples its predecessor's old value.
                if (src.valid) q <= shift_levels(src, s * LPS, (s + 1) * LPS);
                else           q.valid <= 1'b0;
            end
        end
    end

    // Whole pipeline moves unless a result is waiting on a stalled consumer.
    assign advance       = bus.out_ready | ~g_stage[LAT-1].q.valid;
    assign bus.in_ready  = advance;

    assign bus.out_valid = g_stage[LAT-1].q.valid;
    assign bus.out_data  = g_stage[LAT-1].q.data;
    assign bus.out_tag   = g_stage[LAT-1].q.tag;
    assign bus.out_zero  = (g_stage[LAT-1].q.data == '0);
    assign bus.out_err   = (g_stage[LAT-1].q.op > OP_SRA);
    assign bus.out_carry = final_carry(g_stage[LAT-1].q);
endmodule

// File: tb/tb_barrel_shift_pipe.sv
// Self-checking bench for barrel_shift_pipe: directed vector table and corner sequences
// on a 32-bit, 2-stage instance, plus randomised sweeps over several WIDTH/LAT builds
// checked against a bit-level reference model.
module tb_barrel_shift_pipe;
    localparam int W   = 32;
    localparam int LAT = 2;
    localparam int TW  = 4;

    localparam int NCFG = 6;
    localparam int CW [NCFG] = '{8, 8, 32, 32, 64, 64};
    localparam int CL [NCFG] = '{1, 3, 1, 5, 1, 6};
    localparam int NREQ = 150;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic sweep_go   = 1'b0;
    int   sweep_done = 0;

    typedef struct packed {
        logic [127:0] data;
        logic         carry;
    } res_t;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] d;
        logic [4:0]  amt;
        logic [3:0]  tag;
        logic [31:0] ed;
        logic        ec;
        logic        ez;
        logic        ee;
    } vec_t;

    barrel_shift_if #(.WIDTH(W), .TAG_W(TW)) bus ();

    barrel_shift_pipe #(.WIDTH(W), .LAT(LAT), .TAG_W(TW)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: each result bit is picked straight from the operand by index arithmetic.
    function automatic res_t model(input logic [127:0] d, input int n, input logic [2:0] op,
                                   input int w);
        res_t r;
        r.data  = '0;
        r.carry = 1'b0;
        for (int i = 0; i < w; i++) begin
            case (op)
                3'd0:    r.data[i] = d[(i - n + w) % w];
                3'd1:    r.data[i] = d[(i + n) % w];
                3'd2:    r.data[i] = (i >= n) ? d[i-n] : 1'b0;
                3'd3:    r.data[i] = (i + n < w) ? d[i+n] : 1'b0;
                3'd4:    r.data[i] = (i + n < w) ? d[i+n] : d[w-1];
                default: r.data[i] = d[i];
            endcase
        end
        case (op)
            3'd0:       r.carry = r.data[0];
            3'd1:       r.carry = r.data[w-1];
            3'd2:       r.carry = (n == 0) ? 1'b0 : d[w-n];
            3'd3, 3'd4: r.carry = (n == 0) ? 1'b0 : d[n-1];
            default:    r.carry = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic [127:0] cur_out();
        return 128'({bus.out_carry, bus.out_zero, bus.out_err, bus.out_tag, bus.out_data});
    endfunction

    localparam logic [127:0] RESET_OUT = 128'({1'b0, 1'b1, 1'b0, 4'h0, 32'h0});

    // One isolated request: checks acceptance latency and every result field.
    task automatic run_vec(input vec_t v, input string nm);
        int lat;
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.in_data   = v.d;
        bus.in_amt    = v.amt;
        bus.in_op     = v.op;
        bus.in_tag    = v.tag;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check({nm, " latency"}, 128'(lat), 128'(LAT));
        check({nm, " result"}, cur_out(), 128'({v.ec, v.ez, v.ee, v.tag, v.ed}));
    endtask

    vec_t vecs[$];

    initial begin
        logic [127:0] exp_q[$];
        logic [31:0]  bp_data [8];
        logic [4:0]   bp_amt  [8];
        logic [2:0]   bp_op   [8];
        logic         pat     [4];
        logic [127:0] snap;
        logic         stalled;
        res_t         r;
        int           sent, recv, t;

        vecs.push_back('{3'b001, 32'h12345678, 5'd4,  4'hA, 32'h81234567, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{3'b000, 32'h80000001, 5'd1,  4'h1, 32'h00000003, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{3'b010, 32'h00000001, 5'd31, 4'h2, 32'h80000000, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{3'b010, 32'h80000000, 5'd1,  4'h3, 32'h00000000, 1'b1, 1'b1, 1'b0});
        vecs.push_back('{3'b011, 32'h000000F0, 5'd5,  4'h4, 32'h00000007, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{3'b100, 32'h80000000, 5'd31, 4'h5, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{3'b100, 32'h7FFFFFFF, 5'd31, 4'h6, 32'h00000000, 1'b1, 1'b1, 1'b0});
        vecs.push_back('{3'b110, 32'hDEADBEEF, 5'd7,  4'h7, 32'hDEADBEEF, 1'b0, 1'b0, 1'b1});
        vecs.push_back('{3'b111, 32'h00000000, 5'd3,  4'h8, 32'h00000000, 1'b0, 1'b1, 1'b1});
        vecs.push_back('{3'b101, 32'h0000F00D, 5'd9,  4'h9, 32'h0000F00D, 1'b0, 1'b0, 1'b1});
        vecs.push_back('{3'b000, 32'hA5A50F0F, 5'd0,  4'hB, 32'hA5A50F0F, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{3'b001, 32'hA5A50F0F, 5'd0,  4'hC, 32'hA5A50F0F, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{3'b010, 32'hA5A50F0F, 5'd0,  4'hD, 32'hA5A50F0F, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{3'b011, 32'hA5A50F0F, 5'd0,  4'hE, 32'hA5A50F0F, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{3'b100, 32'hA5A50F0F, 5'd0,  4'hF, 32'hA5A50F0F, 1'b0, 1'b0, 1'b0});

        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_amt    = '0;
        bus.in_op     = '0;
        bus.in_tag    = '0;
        bus.out_ready = 1'b0;

        // Reset state, during and after release.
        repeat (2) @(negedge clk);
        check("reset out_valid", 128'(bus.out_valid), 128'(0));
        check("reset in_ready", 128'(bus.in_ready), 128'(1));
        check("reset outputs", cur_out(), RESET_OUT);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle outputs", cur_out(), RESET_OUT);

        for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Back-pressure: 8 requests with out_ready following 1,0,0,1.
        pat = '{1'b1, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 8; i++) begin
            bp_data[i] = $urandom;
            bp_amt[i]  = 5'($urandom_range(0, 31));
            bp_op[i]   = 3'($urandom_range(0, 4));
        end
        sent = 0;
        recv = 0;
        stalled = 1'b0;
        snap = '0;
        for (int c = 0; c < 80 && recv < 8; c++) begin
            @(negedge clk);
            bus.out_ready = pat[c % 4];
            if (sent < 8) begin
                bus.in_valid = 1'b1;
                bus.in_data  = bp_data[sent];
                bus.in_amt   = bp_amt[sent];
                bus.in_op    = bp_op[sent];
                bus.in_tag   = 4'(sent);
            end else begin
                bus.in_valid = 1'b0;
            end
            #1;
            if (stalled) check("bp stable", cur_out(), snap);
            check("bp in_ready", 128'(bus.in_ready), 128'(!(bus.out_valid && !bus.out_ready)));
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) check("bp extra result", cur_out(), '1);
                else                   check("bp result", cur_out(), exp_q.pop_front());
                recv++;
            end
            if (bus.in_valid && bus.in_ready) begin
                r = model(128'(bp_data[sent]), int'(bp_amt[sent]), bp_op[sent], W);
                exp_q.push_back(128'({r.carry, r.data == '0, 1'b0, 4'(sent), r.data[31:0]}));
                sent++;
            end
            stalled = bus.out_valid && !bus.out_ready;
            snap = cur_out();
        end
        check("bp results drained", 128'(recv), 128'(8));
        check("bp queue empty", 128'(exp_q.size()), 128'(0));

        // Reset with two requests in flight.
        @(negedge clk);
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = 32'h11111111;
        bus.in_op     = 3'b000;
        bus.in_amt    = 5'd3;
        bus.in_tag    = 4'h5;
        @(negedge clk);
        bus.in_data = 32'h22222222;
        bus.in_tag  = 4'h6;
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("inflight out_valid", 128'(bus.out_valid), 128'(1));
        #2 rst_n = 1'b0;
        #1;
        check("midreset out_valid", 128'(bus.out_valid), 128'(0));
        check("midreset in_ready", 128'(bus.in_ready), 128'(1));
        check("midreset outputs", cur_out(), RESET_OUT);
        @(negedge clk);
        rst_n = 1'b1;
        run_vec('{3'b001, 32'h12345678, 5'd4, 4'hA, 32'h81234567, 1'b1, 1'b0, 1'b0}, "post reset");
        @(negedge clk);
        bus.out_ready = 1'b1;

        // Randomised sweeps over the other builds.
        sweep_go = 1'b1;
        t = 0;
        while (sweep_done < NCFG && t < 20000) begin
            @(negedge clk);
            t++;
        end
        check("sweeps finished", 128'(sweep_done), 128'(NCFG));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    for (genvar g = 0; g < NCFG; g++) begin : g_sweep
        localparam int SWW = CW[g];
        localparam int SL  = CL[g];
        localparam int SSW = $clog2(SWW);

        barrel_shift_if #(.WIDTH(SWW), .TAG_W(TW)) sb ();

        barrel_shift_pipe #(.WIDTH(SWW), .LAT(SL), .TAG_W(TW)) sdut (
            .clk  (clk),
            .rst_n(rst_n),
            .bus  (sb)
        );

        initial begin
            logic [127:0] q[$];
            logic [127:0] d;
            logic [127:0] act;
            res_t         r;
            int           sent, recv;

            sb.in_valid  = 1'b0;
            sb.in_data   = '0;
            sb.in_amt    = '0;
            sb.in_op     = '0;
            sb.in_tag    = '0;
            sb.out_ready = 1'b0;
            wait (sweep_go);
            sent = 0;
            recv = 0;
            for (int c = 0; c < 4000 && recv < NREQ; c++) begin
                @(negedge clk);
                sb.out_ready = ($urandom_range(0, 3) != 0) || (sent >= NREQ);
                if (sent < NREQ) begin
                    d = {$urandom, $urandom, $urandom, $urandom};
                    sb.in_valid = ($urandom_range(0, 3) != 0);
                    sb.in_data  = d[SWW-1:0];
                    sb.in_amt   = SSW'($urandom_range(0, SWW - 1));
                    sb.in_op    = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7))
                                                              : 3'($urandom_range(0, 4));
                    sb.in_tag   = TW'($urandom);
                end else begin
                    sb.in_valid = 1'b0;
                end
                #1;
                if (sb.out_valid && sb.out_ready) begin
                    act = 128'({sb.out_carry, sb.out_zero, sb.out_err, sb.out_tag, sb.out_data});
                    if (q.size() == 0) check($sformatf("sweep W%0d L%0d extra", SWW, SL), act, '1);
                    else check($sformatf("sweep W%0d L%0d result", SWW, SL), act, q.pop_front());
                    recv++;
                end
                if (sb.in_valid && sb.in_ready) begin
                    r = model(128'(sb.in_data), int'(sb.in_amt), sb.in_op, SWW);
                    q.push_back(128'({r.carry, r.data == '0, sb.in_op > 3'd4, sb.in_tag,
                                      r.data[SWW-1:0]}));
                    sent++;
                end
            end
            check($sformatf("sweep W%0d L%0d count", SWW, SL), 128'(recv), 128'(NREQ));
            sweep_done++;
        end
    end
endmodule
